xfer_arbiter: RTL and testbench

XFER_ARBITER -- requirements
Module: xfer_arbiter

---
 rtl/xfer_arbiter.sv | 172 +++++++++++++++++
 tb/tb_xfer_arbiter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/xfer_arbiter.sv
// Round-robin arbiter that shares one data transfer engine among NUM_REQ requesters.
// FSM: IDLE -> GRANT -> BUSY -> COMPLETE -> IDLE. All outputs are registered.
// Optional BUSY timeout with engine abort, enabled by defining XFER_ARB_TIMEOUT_EN.
module xfer_arbiter #(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned ADDR_WIDTH     = 16,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                          clk_i,
  input  logic                          resetn_i,
  input  logic [NUM_REQ-1:0]            req_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] src_address_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] dst_address_i,
  output logic [NUM_REQ-1:0]            gnt_o,
  output logic [NUM_REQ-1:0]            done_o,
  output logic [NUM_REQ-1:0]            error_o,
  output logic                          busy_o,
  output logic                          eng_start_o,
  output logic [ADDR_WIDTH-1:0]         eng_src_address_o,
  output logic [ADDR_WIDTH-1:0]         eng_dst_address_o,
  output logic                          eng_abort_o,
  input  logic                          eng_done_i,
  input  logic                          eng_error_i
);

  localparam int unsigned IdxW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {StIdle, StGrant, StBusy, StComplete} state_e;

  state_e                r_state, w_state_next;
  logic                  r_armed;
  logic [IdxW-1:0]       r_ptr, r_idx, w_win;
  logic [IdxW:0]         w_sum;
  logic                  w_any_req;
  logic                  w_timeout;
  logic [NUM_REQ-1:0]    w_win_oh, w_idx_oh;

  logic [NUM_REQ-1:0]    r_gnt, r_done, r_err;
  logic                  r_busy, r_start, r_abort;
  logic [ADDR_WIDTH-1:0] r_src, r_dst;

  logic [NUM_REQ-1:0]    w_gnt_d, w_done_d, w_err_d;
  logic                  w_busy_d, w_start_d, w_abort_d;

  // Round-robin search: first requester at or after r_ptr, wrapping to 0.
  always_comb begin
    w_win     = r_ptr;
    w_any_req = 1'b0;
    w_sum     = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      w_sum = {1'b0, r_ptr} + (IdxW+1)'(i);
      if (w_sum >= (IdxW+1)'(NUM_REQ)) w_sum = w_sum - (IdxW+1)'(NUM_REQ);
      if (!w_any_req && req_i[w_sum[IdxW-1:0]]) begin
        w_any_req = 1'b1;
        w_win     = w_sum[IdxW-1:0];
      end
    end
  end

  assign w_win_oh = NUM_REQ'(1) << w_win;
  assign w_idx_oh = NUM_REQ'(1) << r_idx;

`ifdef XFER_ARB_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CntW-1:0] r_busy_cnt;

  // Count elapsed BUSY cycles; cleared on the GRANT->BUSY edge.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      r_busy_cnt <= '0;
    end else if (r_state == StGrant) begin
      r_busy_cnt <= '0;
    end else if (r_state == StBusy) begin
      r_busy_cnt <= r_busy_cnt + CntW'(1);
    end
  end

  assign w_timeout = (r_state == StBusy) && (r_busy_cnt == CntW'(TIMEOUT_CYCLES - 1));
`else
  logic w_unused_timeout;
  assign w_timeout        = 1'b0;
  assign w_unused_timeout = ^TIMEOUT_CYCLES;
`endif

  // State register; r_armed blocks arbitration on the first edge after reset release.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      r_state <= StIdle;
      r_armed <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_armed <= 1'b1;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle:     if (r_armed && w_any_req) w_state_next = StGrant;
      StGrant:    w_state_next = StBusy;
      StBusy:     if (eng_done_i || w_timeout) w_state_next = StComplete;
      StComplete: w_state_next = StIdle;
      default:    w_state_next = StIdle;
    endcase
  end

  // Output next values, keyed on the state being entered so outputs can be registered.
  always_comb begin
    w_gnt_d   = '0;
    w_done_d  = '0;
    w_err_d   = '0;
    w_start_d = 1'b0;
    w_abort_d = 1'b0;
    w_busy_d  = (w_state_next != StIdle);
    case (w_state_next)
      StGrant: begin
        w_gnt_d   = w_win_oh;
        w_start_d = 1'b1;
      end
      StBusy:  w_gnt_d = r_gnt;
      StComplete: begin
        w_done_d = w_idx_oh;
        // eng_done_i wins over a same-cycle timeout.
        if (!eng_done_i || eng_error_i) w_err_d = w_idx_oh;
        w_abort_d = !eng_done_i;
      end
      default: ;
    endcase
  end

  // Output registers, winner/address capture and priority pointer update.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      r_gnt   <= '0;
      r_done  <= '0;
      r_err   <= '0;
      r_busy  <= 1'b0;
      r_start <= 1'b0;
      r_abort <= 1'b0;
      r_src   <= '0;
      r_dst   <= '0;
      r_idx   <= '0;
      r_ptr   <= '0;
    end else begin
      r_gnt   <= w_gnt_d;
      r_done  <= w_done_d;
      r_err   <= w_err_d;
      r_busy  <= w_busy_d;
      r_start <= w_start_d;
      r_abort <= w_abort_d;
      if (r_state == StIdle && w_state_next == StGrant) begin
        r_idx <= w_win;
        r_src <= src_address_i[w_win*ADDR_WIDTH +: ADDR_WIDTH];
        r_dst <= dst_address_i[w_win*ADDR_WIDTH +: ADDR_WIDTH];
      end
      if (r_state == StBusy && w_state_next == StComplete) begin
        r_ptr <= (r_idx == IdxW'(NUM_REQ - 1)) ? '0 : r_idx + IdxW'(1);
      end
    end
  end

  assign gnt_o             = r_gnt;
  assign done_o            = r_done;
  assign error_o           = r_err;
  assign busy_o            = r_busy;
  assign eng_start_o       = r_start;
  assign eng_abort_o       = r_abort;
  assign eng_src_address_o = r_src;
  assign eng_dst_address_o = r_dst;

endmodule

// File: tb/tb_xfer_arbiter.sv
// Self-checking bench for xfer_arbiter: directed scenarios followed by randomized
// transfers checked against a transaction-level round-robin model.
module tb_xfer_arbiter;

  localparam int N  = 4;
  localparam int AW = 16;

  logic            clk = 1'b0;
  logic            resetn;
  logic [N-1:0]    req;
  logic [N*AW-1:0] src, dst;
  logic [N-1:0]    gnt, done, err;
  logic            busy, start, abort;
  logic [AW-1:0]   src_o, dst_o;
  logic            eng_done, eng_error;

  int n_tests = 0;
  int n_fail  = 0;
  int m_ptr   = 0;
  int waits [N];

  always #5 clk = ~clk;

  xfer_arbiter #(
    .NUM_REQ       (N),
    .ADDR_WIDTH    (AW),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk_i            (clk),
    .resetn_i         (resetn),
    .req_i            (req),
    .src_address_i    (src),
    .dst_address_i    (dst),
    .gnt_o            (gnt),
    .done_o           (done),
    .error_o          (err),
    .busy_o           (busy),
    .eng_start_o      (start),
    .eng_src_address_o(src_o),
    .eng_dst_address_o(dst_o),
    .eng_abort_o      (abort),
    .eng_done_i       (eng_done),
    .eng_error_i      (eng_error)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Round-robin rule: first requesting index at or after p, wrapping.
  function automatic int rr_pick(input logic [N-1:0] r, input int p);
    int j;
    for (int i = 0; i < N; i++) begin
      j = (p + i) % N;
      if (r[j]) return j;
    end
    return -1;
  endfunction

  task automatic set_req(input logic [N-1:0] v);
    for (int j = 0; j < N; j++) if (v[j] && !req[j]) waits[j] = 0;
    req = v;
  endtask

  task automatic model_reset();
    m_ptr = 0;
    for (int j = 0; j < N; j++) waits[j] = 0;
  endtask

  task automatic check_all_zero(input string tag);
    check(tag, {gnt, done, err, busy, start, abort, src_o, dst_o}, 64'h0);
  endtask

  task automatic check_idle(input string tag);
    check(tag, {gnt, done, err, busy, start, abort}, 64'h0);
  endtask

  task automatic check_busy(input logic [N-1:0] oh, input logic [AW-1:0] es,
                            input logic [AW-1:0] ed);
    check("b_gnt", gnt, oh);
    check("b_ctl", {busy, start, abort}, 3'b100);
    check("b_done", {done, err}, 0);
    check("b_addr", {src_o, dst_o}, {es, ed});
  endtask

  // Starts in an IDLE cycle with req already driven; ends in the following IDLE cycle.
  task automatic xfer(input int delay, input bit e, input bit tmo, input bit keep,
                      input bit rnd, output int k);
    logic [N-1:0]  oh, nw;
    logic [AW-1:0] es, ed;
    bit            xerr;
    int            n_extra;
    k = rr_pick(req, m_ptr);
    if (k < 0) begin
      check("xfer_no_req", req, 1);
      k = 0;
      return;
    end
    oh = '0;
    oh[k] = 1'b1;
    es = src[k*AW +: AW];
    ed = dst[k*AW +: AW];
    check("fair_wait", (waits[k] <= N - 1), 1);
    for (int j = 0; j < N; j++) if (j != k && req[j]) waits[j]++;
    waits[k] = 0;

    @(negedge clk);  // GRANT
    check("g_start", start, 1);
    check("g_gnt", gnt, oh);
    check("g_busy", busy, 1);
    check("g_done", {done, err, abort}, 0);
    check("g_addr", {src_o, dst_o}, {es, ed});
    if (rnd) begin
      src = {$urandom, $urandom};
      dst = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) req[k] = 1'b0;
      eng_done = ($urandom_range(0, 3) == 0);  // must be ignored in GRANT
      eng_error = 1'b1;
    end

    @(negedge clk);  // first BUSY cycle
    eng_done = 1'b0;
    eng_error = 1'b0;
    check_busy(oh, es, ed);
    n_extra = tmo ? 7 : delay;
    for (int i = 0; i < n_extra; i++) begin
      if (rnd) begin
        src = {$urandom, $urandom};
        dst = {$urandom, $urandom};
      end
      @(negedge clk);
      check_busy(oh, es, ed);
    end
    if (!tmo) begin
      eng_done = 1'b1;
      eng_error = e;
    end

    @(negedge clk);  // COMPLETE
    eng_done = 1'b0;
    eng_error = 1'b0;
    xerr = tmo ? 1'b1 : e;
    check("c_done", done, oh);
    check("c_err", err, xerr ? oh : '0);
    check("c_gnt", gnt, 0);
    check("c_ctl", {busy, start, abort}, {1'b1, 1'b0, tmo});
    check("c_addr", {src_o, dst_o}, {es, ed});
    m_ptr = (k + 1) % N;
    if (!keep) req[k] = 1'b0;
    if (rnd) begin
      nw = req;
      for (int j = 0; j < N; j++) if (j != k && $urandom_range(0, 2) == 0) nw[j] = 1'b1;
      set_req(nw);
      src = {$urandom, $urandom};
      dst = {$urandom, $urandom};
    end

    @(negedge clk);  // IDLE
    check_idle("i_after");
  endtask

  int k;
  int order [5] = '{0, 1, 2, 3, 0};

  initial begin
    resetn = 1'b0;
    req = '0;
    src = '0;
    dst = '0;
    eng_done = 1'b0;
    eng_error = 1'b0;
    model_reset();

    // Reset state, with a request already waiting
    src[2*AW +: AW] = 16'h1000;
    dst[2*AW +: AW] = 16'h2000;
    set_req(4'b0100);
    @(negedge clk);
    check_all_zero("rst_state");
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    check_all_zero("rst_release_quiet");

    // Single request
    xfer(3, 1'b0, 1'b0, 1'b0, 1'b0, k);
    check("single_k", k, 2);

    // Engine error for requester 3
    set_req(4'b1000);
    xfer(2, 1'b1, 1'b0, 1'b0, 1'b0, k);
    check("err_k", k, 3);

    // All requesters held continuously
    set_req(4'b1111);
    for (int i = 0; i < 5; i++) begin
      xfer(1, 1'b0, 1'b0, 1'b1, 1'b0, k);
      check("rr_order", k, order[i]);
    end
    set_req(4'b0000);
    @(negedge clk);
    check_idle("idle_noreq");

    // Reset during BUSY for requester 1
    set_req(4'b0010);
    @(negedge clk);
    check("rb_gnt", {gnt, start}, {4'b0010, 1'b1});
    @(negedge clk);
    check("rb_busy_gnt", gnt, 4'b0010);
    resetn = 1'b0;
    #1;
    check_all_zero("rb_async");
    @(negedge clk);
    check_all_zero("rb_held");
    resetn = 1'b1;
    model_reset();
    @(negedge clk);
    check_all_zero("rb_release_quiet");
    xfer(1, 1'b0, 1'b0, 1'b0, 1'b0, k);
    check("rb_regrant", k, 1);

    // Reset from IDLE clears the pointer: requester 0 wins first
    set_req(4'b1111);
    resetn = 1'b0;
    #1;
    check_all_zero("ri_async");
    @(negedge clk);
    resetn = 1'b1;
    model_reset();
    @(negedge clk);
    check_all_zero("ri_release_quiet");
    xfer(0, 1'b0, 1'b0, 1'b0, 1'b0, k);
    check("first_after_rst", k, 0);

`ifdef XFER_ARB_TIMEOUT_EN
    // Timeout abort, then done/timeout same-cycle precedence
    xfer(0, 1'b0, 1'b1, 1'b0, 1'b0, k);
    check("tmo_k", k, 1);
    xfer(7, 1'b0, 1'b0, 1'b0, 1'b0, k);
    check("prec_k", k, 2);
`endif

    // Randomized transfers
    for (int t = 0; t < 150; t++) begin
      if (req == '0) begin
        if ($urandom_range(0, 3) == 0) begin
          @(negedge clk);
          check_idle("rnd_idle");
        end
        set_req(4'($urandom_range(1, 15)));
      end
      xfer($urandom_range(0, 5), 1'($urandom_range(0, 1)), 1'b0,
           ($urandom_range(0, 2) == 0), 1'b1, k);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
